// File: rtl/axiom_apb_master_arb_if.sv
// Bundle of the requester-side command/response signals and the APB master
// port of axiom_apb_master_arb. The master modport is the arbiter's view;
// the slave modport is the view of whatever drives requests and models the bus.
interface axiom_apb_master_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // requester command side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]          req_wstrb;
  logic [NUM_REQ*3-1:0]          req_prot;
  // requester response side
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_slverr;
  logic                          rsp_timeout;
  // APB master port
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [3:0]                    pwstrb;
  logic [2:0]                    pprot;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pslverr;
  logic                          pready;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pwstrb, pprot,
    input  prdata, pslverr, pready
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pwstrb, pprot,
    output prdata, pslverr, pready
  );
endinterface

// File: rtl/axiom_apb_master_arb.sv
// Round-robin arbiter in front of a single APB master sequencer.
// Each granted requester gets one SETUP + ACCESS transfer; completion is
// reported one cycle later on a one-hot rsp_valid pulse. An optional
// ACCESS-phase timeout ends transfers whose slave never raises pready.
module axiom_apb_master_arb #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   pclk,
  input  logic                   preset,
  axiom_apb_master_arb_if.master bus
);

  localparam int            IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int            CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int            TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);
  localparam bit            TO_EN     = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q;
  logic [IW-1:0]           sel_q;
  logic [IW-1:0]           sel_s;
  logic                    found_s;
  logic                    tmo_s;
  logic                    done_s;
  logic                    grant_s;
  logic [CW-1:0]           cnt_q;

  logic                    psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [3:0]              pwstrb_q;
  logic [2:0]              pprot_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_slverr_q, rsp_timeout_q;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    found_s  = 1'b0;
    sel_s    = ptr_q;
    cand     = 0;
    cand_idx = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = ((int'(ptr_q) + k) >= NUM_REQ) ? (int'(ptr_q) + k - NUM_REQ) : (int'(ptr_q) + k);
      cand_idx = IW'(cand);
      if (!found_s && bus.req_valid[cand_idx]) begin
        found_s = 1'b1;
        sel_s   = cand_idx;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  // A timeout only counts when pready is low; pready on the limit cycle wins.
  assign tmo_s   = TO_EN && (state_q == S_ACCESS) && !bus.pready && (cnt_q == TO_LAST_C);
  assign done_s  = (state_q == S_ACCESS) && (bus.pready || tmo_s);
  // No grant while reset is applied: the command would be dropped at that edge.
  assign grant_s = !preset && found_s && ((state_q == S_IDLE) || done_s);

  assign bus.req_ready   = grant_s ? onehot(sel_s) : {NUM_REQ{1'b0}};
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwstrb      = pwstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Next-state logic for the IDLE/SETUP/ACCESS sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = grant_s ? S_SETUP : S_IDLE;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (done_s) begin
          state_d = grant_s ? S_SETUP : S_IDLE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // APB outputs, latched command, pointer and response registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ptr_q         <= {IW{1'b0}};
      sel_q         <= {IW{1'b0}};
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_WIDTH{1'b0}};
      pwdata_q      <= {DATA_WIDTH{1'b0}};
      pwstrb_q      <= 4'h0;
      pprot_q       <= 3'b000;
      rsp_valid_q   <= {NUM_REQ{1'b0}};
      rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      psel_q    <= (state_d != S_IDLE);
      penable_q <= (state_d == S_ACCESS);
      if (grant_s) begin
        ptr_q    <= (sel_s == LAST_REQ) ? {IW{1'b0}} : (sel_s + 1'b1);
        sel_q    <= sel_s;
        pwrite_q <= bus.req_write[sel_s];
        paddr_q  <= bus.req_addr[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata_q <= bus.req_wdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
        pwstrb_q <= bus.req_wstrb[sel_s*4 +: 4];
        pprot_q  <= bus.req_prot[sel_s*3 +: 3];
      end
      // sel_q/pwrite_q still describe the finishing transfer on the done cycle.
      rsp_valid_q   <= done_s ? onehot(sel_q) : {NUM_REQ{1'b0}};
      rsp_rdata_q   <= (done_s && bus.pready && !pwrite_q) ? bus.prdata : {DATA_WIDTH{1'b0}};
      rsp_slverr_q  <= done_s && (tmo_s || bus.pslverr);
      rsp_timeout_q <= tmo_s;
    end
  end

  // ACCESS wait counter: cleared in SETUP, counts stalled ACCESS cycles.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= {CW{1'b0}};
    end else if (state_q == S_SETUP) begin
      cnt_q <= {CW{1'b0}};
    end else if (TO_EN && (state_q == S_ACCESS) && !bus.pready && (cnt_q != TO_LAST_C)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
